// File: rtl/fxp_cordic_pkg.sv
// Shared constants for the fixed-point CORDIC stages: default Q format,
// the reciprocal hyperbolic gain, and the gain-compensation FSM encoding.
package fxp_cordic_pkg;

  localparam int unsigned C_FXP_WIDTH_DEF = 16;
  localparam int unsigned C_FXP_POINT_DEF = 12;

  // 1/K_h in Q4.12 for the standard hyperbolic iteration set (repeats at 4, 13)
  localparam logic [15:0] C_GAIN_INV_DEF = 16'h1352;

  localparam logic [2:0] C_ST_IDLE = 3'd0;
  localparam logic [2:0] C_ST_MULT = 3'd1;
  localparam logic [2:0] C_ST_NORM = 3'd2;
  localparam logic [2:0] C_ST_DRDY = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE = C_ST_IDLE,
    ST_MULT = C_ST_MULT,
    ST_NORM = C_ST_NORM,
    ST_DRDY = C_ST_DRDY
  } gain_state_e;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational 2W-bit product -> W-bit result with >>> POINT and saturation.
// Round-half-up when FXP_GAIN_ROUND_EN is defined, floor otherwise.
module fxp_round_sat
  import fxp_cordic_pkg::*;
#(
  parameter int unsigned C_FXP_WIDTH = C_FXP_WIDTH_DEF,
  parameter int unsigned C_FXP_POINT = C_FXP_POINT_DEF
) (
  input  logic [2*C_FXP_WIDTH-1:0] prod,
  output logic [C_FXP_WIDTH-1:0]   res,
  output logic                     sat
);

  // one guard bit so a rounding carry cannot wrap the product
  localparam int unsigned C_EW = 2*C_FXP_WIDTH + 1;

  logic signed [C_EW-1:0]          ext;
  logic signed [C_EW-1:0]          shifted;
  logic [C_EW-C_FXP_WIDTH:0]       top;

  always_comb begin
    ext = C_EW'(signed'(prod));
`ifdef FXP_GAIN_ROUND_EN
    ext = ext + (C_EW'(1) << (C_FXP_POINT - 1));
`endif
    shifted = ext >>> C_FXP_POINT;
    // in range only when every bit above the result MSB copies the sign
    top = shifted[C_EW-1:C_FXP_WIDTH-1];
    sat = !((&top) || !(|top));
    if (sat) begin
      res = shifted[C_EW-1] ? {1'b1, {(C_FXP_WIDTH-1){1'b0}}}
                            : {1'b0, {(C_FXP_WIDTH-1){1'b1}}};
    end else begin
      res = shifted[C_FXP_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fxp_cordic_hv_gain.sv
// Hyperbolic CORDIC gain compensation: X * (1/K_h) via serial shift-add,
// then round/saturate. FXP_GAIN_ROUND_EN selects round-half-up over floor.
module fxp_cordic_hv_gain
  import fxp_cordic_pkg::*;
#(
  parameter int unsigned             C_FXP_WIDTH = C_FXP_WIDTH_DEF,
  parameter int unsigned             C_FXP_POINT = C_FXP_POINT_DEF,
  parameter logic [C_FXP_WIDTH-1:0]  C_GAIN_INV  = C_FXP_WIDTH'(C_GAIN_INV_DEF),
  parameter int unsigned             C_CNT_SIZE  = $clog2(C_FXP_WIDTH + 1)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   DIN_VALID,
  input  logic [C_FXP_WIDTH-1:0] DIN,
  input  logic                   DIN_OVF,
  output logic                   BUSY,
  output logic                   DOUT_VALID,
  output logic [C_FXP_WIDTH-1:0] DOUT,
  output logic                   DOUT_OVF,
  output logic                   ERR_DROP
);

  localparam int unsigned C_PW = 2*C_FXP_WIDTH;

  gain_state_e             state_q, state_d;
  logic [C_PW-1:0]         acc_q, acc_d;
  logic [C_PW-1:0]         opnd_q, opnd_d;
  logic [C_FXP_WIDTH-1:0]  gain_q, gain_d;
  logic [C_CNT_SIZE-1:0]   cnt_q, cnt_d;
  logic                    in_ovf_q, in_ovf_d;
  logic [C_FXP_WIDTH-1:0]  res_q, res_d;
  logic                    res_ovf_q, res_ovf_d;
  logic                    busy_q, busy_d;
  logic                    dout_valid_q, dout_valid_d;
  logic [C_FXP_WIDTH-1:0]  dout_q, dout_d;
  logic                    dout_ovf_q, dout_ovf_d;
  logic                    err_drop_q, err_drop_d;

  logic [C_FXP_WIDTH-1:0]  rs_res;
  logic                    rs_sat;

  fxp_round_sat #(
    .C_FXP_WIDTH (C_FXP_WIDTH),
    .C_FXP_POINT (C_FXP_POINT)
  ) u_round_sat (
    .prod (acc_q),
    .res  (rs_res),
    .sat  (rs_sat)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    opnd_d       = opnd_q;
    gain_d       = gain_q;
    cnt_d        = cnt_q;
    in_ovf_d     = in_ovf_q;
    res_d        = res_q;
    res_ovf_d    = res_ovf_q;
    dout_valid_d = 1'b0;
    dout_d       = dout_q;
    dout_ovf_d   = dout_ovf_q;
    err_drop_d   = err_drop_q;

    case (state_q)
      ST_IDLE: begin
        if (DIN_VALID) begin
          opnd_d   = {{C_FXP_WIDTH{DIN[C_FXP_WIDTH-1]}}, DIN};
          gain_d   = C_GAIN_INV;
          in_ovf_d = DIN_OVF;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_MULT;
        end
      end
      ST_MULT: begin
        // gain is consumed LSB first, so bit[cnt] is always gain_q[0]
        if (gain_q[0]) begin
          acc_d = acc_q + opnd_q;
        end
        opnd_d = opnd_q << 1;
        gain_d = gain_q >> 1;
        cnt_d  = cnt_q + C_CNT_SIZE'(1);
        if (cnt_q == C_CNT_SIZE'(C_FXP_WIDTH - 1)) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        res_d     = rs_res;
        res_ovf_d = in_ovf_q | rs_sat;
        state_d   = ST_DRDY;
      end
      ST_DRDY: begin
        dout_d       = res_q;
        dout_ovf_d   = res_ovf_q;
        dout_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (DIN_VALID && (state_q != ST_IDLE)) begin
      err_drop_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      opnd_q       <= '0;
      gain_q       <= '0;
      cnt_q        <= '0;
      in_ovf_q     <= 1'b0;
      res_q        <= '0;
      res_ovf_q    <= 1'b0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_ovf_q   <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      opnd_q       <= opnd_d;
      gain_q       <= gain_d;
      cnt_q        <= cnt_d;
      in_ovf_q     <= in_ovf_d;
      res_q        <= res_d;
      res_ovf_q    <= res_ovf_d;
      busy_q       <= busy_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_ovf_q   <= dout_ovf_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign BUSY       = busy_q;
  assign DOUT_VALID = dout_valid_q;
  assign DOUT       = dout_q;
  assign DOUT_OVF   = dout_ovf_q;
  assign ERR_DROP   = err_drop_q;

endmodule
